pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16).
REQ-005 Ports: clk in 1 clock, rising edge active. The single clock SHALL be clk, and the reset SHALL be asynchronous and active-low on rst_n.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 stall  in  1  hold PC; fetch stage busy.
REQ-008 halt  in  1  request HALT state.
REQ-009 resume  in  1  leave HALT state.
REQ-010 exception  in  1  redirect to EXC_VECTOR.
REQ-011 jump, jump_target  in  1/WIDTH  unconditional redirect.
REQ-012 branch_taken, branch_target  in  1/WIDTH  conditional redirect.
REQ-013 call, ret  in  1/1  push pc+4 / pop-and-redirect (RAS).
REQ-014 pc, pc_plus4  out  WIDTH/WIDTH  current PC; pc+4 modulo 2^WIDTH.
REQ-015 pc_valid, misaligned, ras_underflow  out  1/1/1  fetch valid; target bits[1:0]!=0 (1-cycle pulse); ret on empty stack (1-cycle pulse).

Function
REQ-016 States BOOT, RUN, HALT; reset enters BOOT; BOOT->RUN unconditionally after one cycle, pc held at RESET_VECTOR, pc_valid=0.
REQ-017 In RUN, next-PC priority per cycle: exception > ret > jump > branch_taken > stall(hold) > pc+4.
REQ-018 Redirects (exception, ret, jump, branch) SHALL override stall in the same cycle.
REQ-019 Latency: new pc visible on the rising edge following the cycle the select input is sampled; pc_plus4 combinational from pc.
REQ-020 Sequential increment wraps 2^WIDTH-4 -> 0 with no flag.
REQ-021 Any loaded target with bits[1:0]!=0: pc loads target with bits[1:0] forced 0; misaligned pulses for one cycle.
REQ-022 RUN->HALT when halt=1 and no redirect; in HALT pc held, pc_valid=0; HALT->RUN on resume (pc unchanged) or exception (pc=EXC_VECTOR).
REQ-023 halt and a redirect in the same cycle: redirect taken, halt applied the following cycle if still asserted.
REQ-024 pc_valid=1 only in RUN.

Reset
REQ-025 On rst_n low, asynchronously: state=BOOT, pc=RESET_VECTOR, pc_valid=0, misaligned=0, ras_underflow=0, RAS count=0, RAS pointer=0.
REQ-026 Reset asserted mid-operation discards any pending redirect and stack contents.

Configuration
REQ-027 Macro PC_UNIT_RAS_EN: when defined, a RAS_DEPTH circular return-address stack is built; call pushes pc+4; ret pops into pc.
REQ-028 Push on full stack overwrites oldest entry; count saturates at RAS_DEPTH.
REQ-029 Ret on empty stack: pc <= pc+4, ras_underflow pulses, count stays 0.
REQ-030 Call and ret together: pop target used, then pc+4 of the current pc replaces the top (count unchanged).
REQ-031 Without PC_UNIT_RAS_EN: call/ret ports present but ignored, ras_underflow tied 0, no stack storage.

Structure
REQ-032 Shared package pc_pkg holds the state enum (BOOT, RUN, HALT), the next-PC select encoding, and the constant PC_STEP=4.
REQ-033 The stack SHALL be a sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-034 Reset release, 4 free-running cycles -> pc 0x0 (BOOT, valid=0), then 0x0, 0x4, 0x8 with valid=1.
REQ-035 stall=1 with branch_taken=1, target 0x100 in the same cycle -> pc=0x100 next edge; stall alone then holds 0x100.
REQ-036 exception, jump 0x40 and branch 0x80 asserted together -> pc=0x80 (EXC_VECTOR); jump_target 0x42 -> pc=0x40, misaligned pulses.
REQ-037 pc=0xFFFF_FFFC, no control -> pc=0x0 next cycle.
REQ-038 RAS_EN: call at pc 0x10, call at 0x20, ret, ret, ret -> pc 0x24, 0x14, then pc+4 with ras_underflow=1; 5 calls at depth 4 then 4 rets return the 4 newest addresses.
REQ-039 halt in RUN -> valid=0, pc frozen; resume -> valid=1 same pc; rst_n pulse mid-stack -> pc=RESET_VECTOR, next ret underflows.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Source of the next PC value
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_EXC    = 3'd2,
        SEL_RET    = 3'd3,
        SEL_JUMP   = 3'd4,
        SEL_BRANCH = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;
    logic             do_pop;

    assign top_idx = ptr_q - PTR_W'(1);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign top_o   = mem_q[top_idx];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push_i && !do_pop) begin
            ptr_d   = ptr_q + PTR_W'(1);
            count_d = full_o ? count_q : count_q + CNT_W'(1);
        end else if (do_pop && !push_i) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Simultaneous push and pop replaces the top entry in place
    always_ff @(posedge clk) begin
        if (push_i && do_pop) begin
            mem_q[top_idx] <= push_data_i;
        end else if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT control, prioritised redirects, optional RAS.
// Build option: define PC_UNIT_RAS_EN to include the return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             exception_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             call_i,
    input  logic             ret_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pc_valid_o,
    output logic             misaligned_o,
    output logic             ras_underflow_o
);

    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q;
    logic             misaligned_q, misaligned_d;
    logic             ras_underflow_q, ras_underflow_d;
    logic [WIDTH-1:0] target;
    logic             load;
    logic             ret_en;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;

    assign pc_plus4_o = pc_q + WIDTH'(PC_STEP);

    always_comb begin
        state_d         = state_q;
        sel             = SEL_HOLD;
        ras_underflow_d = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (exception_i) begin
                    sel = SEL_EXC;
                end else if (ret_en) begin
                    if (ras_empty) begin
                        sel             = SEL_INC;
                        ras_underflow_d = 1'b1;
                    end else begin
                        sel = SEL_RET;
                    end
                end else if (jump_i) begin
                    sel = SEL_JUMP;
                end else if (branch_taken_i) begin
                    sel = SEL_BRANCH;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else if (!stall_i) begin
                    sel = SEL_INC;
                end
            end
            ST_HALT: begin
                if (exception_i) begin
                    sel     = SEL_EXC;
                    state_d = ST_RUN;
                end else if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Target mux; loaded targets are word-aligned and flag dropped low bits
    always_comb begin
        target = '0;
        load   = 1'b1;
        case (sel)
            SEL_EXC:    target = EXC_VECTOR;
            SEL_RET:    target = ras_top;
            SEL_JUMP:   target = jump_target_i;
            SEL_BRANCH: target = branch_target_i;
            default:    load   = 1'b0;
        endcase
        misaligned_d = load && (|target[1:0]);
        if (load) begin
            pc_d = target & ~WIDTH'(PC_STEP - 1);
        end else if (sel == SEL_INC) begin
            pc_d = pc_plus4_o;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VECTOR;
            pc_valid_q      <= 1'b0;
            misaligned_q    <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= (state_d == ST_RUN);
            misaligned_q    <= misaligned_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign misaligned_o    = misaligned_q;
    assign ras_underflow_o = ras_underflow_q;

`ifdef PC_UNIT_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_full_unused;

    assign ret_en   = ret_i;
    assign ras_push = (state_q == ST_RUN) && call_i;
    assign ras_pop  = (sel == SEL_RET);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus4_o),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full_unused)
    );
`else
    logic ras_unused;

    assign ret_en     = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_unused = call_i ^ ret_i;
`endif

endmodule
